acc_core_seq: RTL and testbench

Host-side sequencer for the 8-bit accumulator core. It takes a byte-wide valid/ready command stream and turns it into core-facing controls: program-memory write strobes, run enable, single-step, and core reset. It also counts retired instructions and stops a runaway program with a watchdog. It sits between the chip I/O pins and the core, replacing direct pin control of the core's write-enable and address.

---
 rtl/acc_core_seq_if.sv | 9 +
 rtl/acc_core_seq.sv | 247 ++++++++++++++++++++++++
 tb/tb_acc_core_seq.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_core_seq_if.sv
// Byte-wide valid/ready command stream from the host pins into the sequencer.
interface acc_core_seq_if;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_ready;

    modport master (output cmd_valid, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_data, output cmd_ready);
endinterface

// File: rtl/acc_core_seq.sv
// Host-side sequencer for the 8-bit accumulator core: decodes host command bytes into
// program-memory writes, run/step/reset controls, and counts retired instructions with a watchdog.
module acc_core_seq #(
    parameter int unsigned MEM_DEPTH = 30,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned RUN_LIMIT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    acc_core_seq_if.slave     cmd,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              core_run,
    output logic              core_rst_n,
    input  logic              core_instr_done,
    input  logic              core_halted,
    output logic              busy,
    output logic              err,
    output logic              timeout,
    output logic [CNT_W-1:0]  instr_count
);

    localparam int unsigned DATA_W = 8;

    localparam logic [DATA_W-1:0] OP_LOAD  = 8'h10;
    localparam logic [DATA_W-1:0] OP_RUN   = 8'h20;
    localparam logic [DATA_W-1:0] OP_STEP  = 8'h30;
    localparam logic [DATA_W-1:0] OP_STOP  = 8'h40;
    localparam logic [DATA_W-1:0] OP_CRST  = 8'h50;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_LEN  = 3'd1,
        S_LOAD_DATA = 3'd2,
        S_RUNNING   = 3'd3,
        S_STEPPING  = 3'd4,
        S_CORE_RST  = 3'd5
    } state_e;

    state_e state_q, state_d;

    logic              cmd_ready_q,   cmd_ready_d;
    logic              mem_we_q,      mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,    mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q,   mem_wdata_d;
    logic              core_run_q,    core_run_d;
    logic              core_rst_n_q,  core_rst_n_d;
    logic              busy_q,        busy_d;
    logic              err_q,         err_d;
    logic              timeout_q,     timeout_d;
    logic [CNT_W-1:0]  instr_count_q, instr_count_d;
    logic [ADDR_W-1:0] ptr_q,         ptr_d;
    logic [ADDR_W-1:0] last_q,        last_d;
    logic              rst_cnt_q,     rst_cnt_d;

    logic              accept_c;
    logic              is_stop_c;
    logic              hdr_ok_c;
    logic              len_ok_c;
    logic              last_byte_c;
    logic [CNT_W-1:0]  cnt_inc_c;
    logic [CNT_W-1:0]  cnt_new_c;
    logic              limit_hit_c;
    logic              stop_c;

    // Shared decode of the current byte and retire pulse.
    assign accept_c    = cmd.cmd_valid & cmd_ready_q;
    assign is_stop_c   = (cmd.cmd_data == OP_STOP);
    assign stop_c      = accept_c & is_stop_c;
    assign hdr_ok_c    = (cmd.cmd_data == OP_LOAD) || (cmd.cmd_data == OP_RUN)  ||
                         (cmd.cmd_data == OP_STEP) || (cmd.cmd_data == OP_STOP) ||
                         (cmd.cmd_data == OP_CRST);
    assign len_ok_c    = (cmd.cmd_data != 8'd0) && (32'(cmd.cmd_data) <= MEM_DEPTH);
    assign last_byte_c = (ptr_q == last_q);
    assign cnt_inc_c   = (&instr_count_q) ? instr_count_q : instr_count_q + CNT_W'(1);
    assign cnt_new_c   = core_instr_done ? cnt_inc_c : instr_count_q;
    assign limit_hit_c = (32'(cnt_new_c) >= RUN_LIMIT);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    case (cmd.cmd_data)
                        OP_LOAD: state_d = S_LOAD_LEN;
                        OP_RUN:  state_d = S_RUNNING;
                        OP_STEP: state_d = S_STEPPING;
                        OP_CRST: state_d = S_CORE_RST;
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_LOAD_LEN: begin
                if (accept_c) begin
                    state_d = len_ok_c ? S_LOAD_DATA : S_IDLE;
                end
            end
            S_LOAD_DATA: begin
                if (accept_c && last_byte_c) begin
                    state_d = S_IDLE;
                end
            end
            S_RUNNING: begin
                if (core_halted || stop_c || limit_hit_c) begin
                    state_d = S_IDLE;
                end
            end
            S_STEPPING: begin
                // A step that never started (core already halted) ends immediately.
                if (!core_run_q || core_instr_done || core_halted) begin
                    state_d = S_IDLE;
                end
            end
            S_CORE_RST: begin
                if (rst_cnt_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        ptr_d         = ptr_q;
        last_d        = last_q;
        err_d         = err_q;
        timeout_d     = timeout_q;
        instr_count_d = instr_count_q;
        rst_cnt_d     = (state_q == S_CORE_RST);
        cmd_ready_d   = (state_d == S_IDLE)      || (state_d == S_LOAD_LEN) ||
                        (state_d == S_LOAD_DATA) || (state_d == S_RUNNING);
        busy_d        = (state_d != S_IDLE);
        core_rst_n_d  = (state_d != S_CORE_RST);
        core_run_d    = (state_d == S_RUNNING) ||
                        ((state_d == S_STEPPING) &&
                         ((state_q == S_STEPPING) ? core_run_q : !core_halted));

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    err_d = !hdr_ok_c;
                    if ((cmd.cmd_data == OP_RUN) || (cmd.cmd_data == OP_STEP)) begin
                        timeout_d     = 1'b0;
                        instr_count_d = '0;
                    end
                end
            end
            S_LOAD_LEN: begin
                if (accept_c) begin
                    if (len_ok_c) begin
                        ptr_d  = '0;
                        last_d = ADDR_W'(cmd.cmd_data - 8'd1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD_DATA: begin
                if (accept_c) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ptr_q;
                    mem_wdata_d = cmd.cmd_data;
                    if (!last_byte_c) begin
                        ptr_d = ptr_q + ADDR_W'(1);
                    end
                end
            end
            S_RUNNING: begin
                instr_count_d = cnt_new_c;
                if (accept_c && !is_stop_c) begin
                    err_d = 1'b1;
                end
                // Watchdog only claims the stop when halt/STOP did not end the run this cycle.
                if (limit_hit_c && !core_halted && !stop_c) begin
                    timeout_d = 1'b1;
                end
            end
            S_STEPPING: begin
                if (core_run_q) begin
                    instr_count_d = cnt_new_c;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready_q   <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            core_run_q    <= 1'b0;
            core_rst_n_q  <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            timeout_q     <= 1'b0;
            instr_count_q <= '0;
            ptr_q         <= '0;
            last_q        <= '0;
            rst_cnt_q     <= 1'b0;
        end else begin
            cmd_ready_q   <= cmd_ready_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            core_run_q    <= core_run_d;
            core_rst_n_q  <= core_rst_n_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
            timeout_q     <= timeout_d;
            instr_count_q <= instr_count_d;
            ptr_q         <= ptr_d;
            last_q        <= last_d;
            rst_cnt_q     <= rst_cnt_d;
        end
    end

    assign cmd.cmd_ready = cmd_ready_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign core_run      = core_run_q;
    assign core_rst_n    = core_rst_n_q;
    assign busy          = busy_q;
    assign err           = err_q;
    assign timeout       = timeout_q;
    assign instr_count   = instr_count_q;

endmodule

// File: tb/tb_acc_core_seq.sv
// Directed bench for acc_core_seq with a small behavioural core model (RUN_LIMIT=4).
module tb_acc_core_seq;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned CNT_W  = 16;

    logic              clk;
    logic              rst_n;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              core_run;
    logic              core_rst_n;
    logic              core_instr_done;
    logic              core_halted;
    logic              busy;
    logic              err;
    logic              timeout;
    logic [CNT_W-1:0]  instr_count;

    acc_core_seq_if cmd_if ();

    acc_core_seq #(
        .MEM_DEPTH (30),
        .ADDR_W    (ADDR_W),
        .CNT_W     (CNT_W),
        .RUN_LIMIT (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd             (cmd_if),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .core_run        (core_run),
        .core_rst_n      (core_rst_n),
        .core_instr_done (core_instr_done),
        .core_halted     (core_halted),
        .busy            (busy),
        .err             (err),
        .timeout         (timeout),
        .instr_count     (instr_count)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Core model state
    int   halt_after = 0;
    int   retired    = 0;
    int   halt_cyc   = 0;
    logic ph         = 1'b0;

    // Monitor state
    int          we_n = 0;
    logic [7:0]  we_addr [64];
    logic [7:0]  we_data [64];
    int          we_cyc  [64];
    logic        we_busy [64];
    logic        run_seen = 1'b0;
    int          rstlow   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Core: retires one instruction every other cycle while running; halts after halt_after retirements.
    initial forever begin
        @(negedge clk);
        core_instr_done = 1'b0;
        if (core_run && !core_halted) begin
            if (halt_after != 0 && retired == halt_after) begin
                core_halted = 1'b1;
                halt_cyc    = cyc;
            end else begin
                ph = ~ph;
                if (ph) begin
                    core_instr_done = 1'b1;
                    retired++;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (core_run) run_seen = 1'b1;
        if (!core_rst_n) rstlow++;
        if (mem_we && we_n < 64) begin
            we_addr[we_n] = 8'(mem_addr);
            we_data[we_n] = mem_wdata;
            we_cyc[we_n]  = cyc;
            we_busy[we_n] = busy;
            we_n++;
        end
    end

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_data  = b;
        while (cmd_if.cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk_eq("send_ready", 64'(cmd_if.cmd_ready), 64'd1);
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk_eq(tag, 64'(busy), 64'd0);
    endtask

    task automatic wait_run_low(output int fall);
        int n = 0;
        while (core_run !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        fall = cyc;
        chk_eq("run_low", 64'(core_run), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        logic [7:0] ld_bytes [3];
        int fall;
        ld_bytes = '{8'h01, 8'h05, 8'h0A};

        rst_n            = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_data  = 8'h00;
        core_instr_done  = 1'b0;
        core_halted      = 1'b0;

        repeat (2) @(negedge clk);
        chk_eq("rst_ctl", 64'({cmd_if.cmd_ready, core_rst_n, core_run, busy, err, timeout, mem_we}), 64'd0);
        chk_eq("rst_dat", 64'({mem_addr, mem_wdata, instr_count}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_eq("rel_ctl", 64'({cmd_if.cmd_ready, core_rst_n, core_run, busy, err, timeout, mem_we}), 64'b1100000);
        chk_eq("rel_dat", 64'({mem_addr, mem_wdata, instr_count}), 64'd0);

        // Three-byte load, back to back
        we_n = 0; run_seen = 1'b0;
        send(8'h10); send(8'h03); send(8'h01); send(8'h05); send(8'h0A);
        repeat (3) @(negedge clk);
        chk_eq("ld_n", 64'(we_n), 64'd3);
        for (int i = 0; i < 3; i++) begin
            chk_eq("ld_addr", 64'(we_addr[i]), 64'(i));
            chk_eq("ld_data", 64'(we_data[i]), 64'(ld_bytes[i]));
        end
        chk_eq("ld_b2b", 64'(we_cyc[2] - we_cyc[0]), 64'd2);
        chk_eq("ld_last_idle", 64'(we_busy[2]), 64'd0);
        chk_eq("ld_busy", 64'(busy), 64'd0);
        chk_eq("ld_norun", 64'(run_seen), 64'd0);

        // Full-depth load: 30 bytes, last address 29
        we_n = 0;
        send(8'h10); send(8'd30);
        for (int i = 0; i < 30; i++) send(8'(i * 7 + 3));
        repeat (3) @(negedge clk);
        chk_eq("full_n", 64'(we_n), 64'd30);
        chk_eq("full_addr29", 64'(we_addr[29]), 64'd29);
        chk_eq("full_data29", 64'(we_data[29]), 64'hCE);
        chk_eq("full_err", 64'(err), 64'd0);

        // Bad lengths
        we_n = 0;
        send(8'h10); send(8'h00);
        @(negedge clk);
        chk_eq("len0_err", 64'(err), 64'd1);
        chk_eq("len0_busy", 64'(busy), 64'd0);
        send(8'h10);
        chk_eq("hdr_clr_err", 64'(err), 64'd0);
        send(8'h1F);
        @(negedge clk);
        chk_eq("len31_err", 64'(err), 64'd1);
        chk_eq("badlen_nowe", 64'(we_n), 64'd0);

        // STOP in IDLE is a no-op header; unknown opcode flags err
        send(8'h40);
        @(negedge clk);
        chk_eq("stop_idle", 64'({busy, err}), 64'd0);
        send(8'h77);
        @(negedge clk);
        chk_eq("badop_err", 64'({busy, err}), 64'b01);

        // RUN: core retires 3 then halts
        retired = 0; ph = 1'b0; halt_after = 3;
        send(8'h20);
        chk_eq("run_err_clr", 64'(err), 64'd0);
        chk_eq("run_on", 64'(core_run), 64'd1);
        wait_run_low(fall);
        chk_eq("halt_lat", 64'(fall - halt_cyc), 64'd1);
        chk_eq("halt_cnt", 64'(instr_count), 64'd3);
        chk_eq("halt_tmo", 64'(timeout), 64'd0);
        chk_eq("halt_busy", 64'(busy), 64'd0);
        core_halted = 1'b0; halt_after = 0;

        // RUN: never halts, watchdog at 4
        retired = 0; ph = 1'b0;
        send(8'h20);
        wait_run_low(fall);
        chk_eq("wd_cnt", 64'(instr_count), 64'd4);
        chk_eq("wd_tmo", 64'(timeout), 64'd1);
        chk_eq("wd_retired", 64'(retired), 64'd4);
        chk_eq("wd_busy", 64'(busy), 64'd0);

        // RUN then STOP
        retired = 0; ph = 1'b0;
        send(8'h20); send(8'h40);
        @(negedge clk);
        chk_eq("stop_ctl", 64'({core_run, busy, err, timeout}), 64'd0);
        chk_eq("stop_cnt", 64'(instr_count), 64'd1);

        // RUN then junk byte: err, run continues to watchdog
        retired = 0; ph = 1'b0;
        send(8'h20); send(8'h99);
        chk_eq("junk_err", 64'(err), 64'd1);
        chk_eq("junk_run", 64'({core_run, busy}), 64'b11);
        wait_run_low(fall);
        chk_eq("junk_cnt", 64'(instr_count), 64'd4);
        chk_eq("junk_tmo_err", 64'({timeout, err}), 64'b11);

        // STEP: exactly one instruction
        retired = 0; ph = 1'b0;
        send(8'h30);
        chk_eq("step_clr", 64'({timeout, err}), 64'd0);
        wait_idle("step_idle");
        chk_eq("step_cnt", 64'(instr_count), 64'd1);
        chk_eq("step_retired", 64'(retired), 64'd1);
        chk_eq("step_run", 64'(core_run), 64'd0);

        // STEP with core already halted
        core_halted = 1'b1; retired = 0; run_seen = 1'b0;
        send(8'h30);
        wait_idle("steph_idle");
        chk_eq("steph_norun", 64'(run_seen), 64'd0);
        chk_eq("steph_cnt", 64'(instr_count), 64'd0);
        core_halted = 1'b0;

        // Core reset pulse width
        rstlow = 0;
        send(8'h50);
        repeat (5) @(negedge clk);
        chk_eq("crst_width", 64'(rstlow), 64'd2);
        chk_eq("crst_after", 64'({cmd_if.cmd_ready, core_rst_n, busy}), 64'b110);

        // Async reset during LOAD_DATA
        send(8'h10); send(8'h05); send(8'h11);
        chk_eq("arst_pre_we", 64'({mem_we, mem_wdata}), 64'h111);
        #2 rst_n = 1'b0;
        #1;
        chk_eq("arst_ctl", 64'({cmd_if.cmd_ready, core_rst_n, core_run, busy, err, timeout, mem_we}), 64'd0);
        chk_eq("arst_dat", 64'({mem_addr, mem_wdata, instr_count}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_eq("arst_rel", 64'({cmd_if.cmd_ready, core_rst_n, busy}), 64'b110);
        send(8'h10);
        chk_eq("arst_hdr", 64'(busy), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
